rpn_stack_engine: RTL and testbench

Operand stack and execution unit for the RPN calculator. It sits directly downstream of the stack-pointer logic and replaces the bare pointer register with a complete push/pop/operate engine. The engine holds a cached top-of-stack (TOS) register, an entry counter and a synchronous RAM for the deeper entries. It accepts one command at a time over a valid/ready handshake and presents TOS for the HEX display path.

---
 rtl/rpn_pkg.sv | 17 +
 rtl/rpn_stack_ram.sv | 19 +
 rtl/rpn_stack_engine.sv | 88 ++++++++
 tb/tb_rpn_stack_engine.sv | 119 +++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// rpn_pkg: opcodes, error codes and FSM state encoding shared by the RPN stack engine.
package rpn_pkg;
  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_AND   = 3'd5;
  localparam logic [2:0] OP_OR    = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UDF  = 2'd2;
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WB   = 1'b1;
endpackage

// File: rtl/rpn_stack_ram.sv
// rpn_stack_ram: simple dual-port RAM holding the stack entries below TOS, registered read.
module rpn_stack_ram #(
  parameter int WIDTH = 8,
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: RPN operand stack with cached TOS, RAM-backed deeper entries and a one-cycle write-back ALU.
module rpn_stack_engine
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] top_data,
  output logic             top_valid,
  output logic [AW:0]      count,
  output logic             err_pulse,
  output logic [1:0]       err_code
);
  localparam logic [AW:0] ONE = 1;
  localparam logic [AW:0] TWO = 2;
  state_t state;
  logic [2:0] op_q;
  logic [WIDTH-1:0] tos, nos, alu;
  logic fire, full, empty, multi, binop, reject, go_wb, we;
  logic [1:0] err_new;
  assign cmd_ready = state == ST_IDLE;
  assign fire = cmd_valid && cmd_ready;
  assign full = count[AW];
  assign empty = count == '0;
  assign multi = count >= TWO;
  assign binop = cmd_op >= OP_ADD && cmd_op <= OP_OR;
  assign err_new = (cmd_op == OP_PUSH && full) ? ERR_OVF :
                   ((cmd_op == OP_POP && empty) || (binop && !multi)) ? ERR_UDF : ERR_NONE;
  assign reject = err_new != ERR_NONE;
  assign go_wb = fire && multi && (binop || cmd_op == OP_POP);
  assign we = fire && cmd_op == OP_PUSH && !full && !empty;
  assign top_data = tos;
  assign top_valid = !empty;
  rpn_stack_ram #(.WIDTH(WIDTH), .AW(AW)) u_ram (
    .clk(CLOCK_50),
    .we(we),
    .waddr(AW'(count - ONE)),
    .wdata(tos),
    .re(go_wb),
    .raddr(AW'(count - TWO)),
    .rdata(nos)
  );
  // POP reuses the write-back path: the default arm just forwards NOS.
  always_comb begin
    case (op_q)
      OP_ADD:  alu = nos + tos;
      OP_SUB:  alu = nos - tos;
      OP_MUL:  alu = nos * tos;
      OP_AND:  alu = nos & tos;
      OP_OR:   alu = nos | tos;
      default: alu = nos;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      op_q <= OP_PUSH;
      tos <= '0;
      count <= '0;
      err_pulse <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      err_pulse <= fire && reject;
      if (fire) err_code <= err_new;
      if (state == ST_WB) begin
        tos <= alu;
        count <= count - ONE;
        state <= ST_IDLE;
      end else if (fire && !reject) begin
        op_q <= cmd_op;
        if (go_wb) state <= ST_WB;
        else if (cmd_op == OP_PUSH) begin
          tos <= cmd_data;
          count <= count + ONE;
        end else begin
          tos <= '0;
          count <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rpn_stack_engine.sv
// tb_rpn_stack_engine: directed and random commands checked against a queue-based stack model.
module tb_rpn_stack_engine;
  import rpn_pkg::*;
  logic CLOCK_50, RESET_N, cmd_valid, cmd_ready, top_valid, err_pulse;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data, top_data;
  logic [2:0] count;
  logic [1:0] err_code;
  int errors = 0, checks = 0;
  int stk[$];
  rpn_stack_engine #(.WIDTH(8), .AW(2)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .top_data(top_data), .top_valid(top_valid),
    .count(count), .err_pulse(err_pulse), .err_code(err_code)
  );
  initial CLOCK_50 = 0;
  always #5 CLOCK_50 = ~CLOCK_50;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_state(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_count"}, count, stk.size());
    chk({tag, "_top"}, top_data, stk.size() > 0 ? stk[$] : 0);
    chk({tag, "_tvalid"}, top_valid, stk.size() > 0);
  endtask
  task automatic step(input logic [2:0] op, input logic [7:0] d);
    bit wb;
    int e, a, b, r;
    wb = 0; e = 0; r = 0;
    if (op == OP_PUSH) begin
      if (stk.size() == 4) e = 1; else stk.push_back(d);
    end else if (op == OP_POP) begin
      if (stk.size() == 0) e = 2;
      else begin wb = stk.size() >= 2; void'(stk.pop_back()); end
    end else if (op == OP_CLEAR) stk.delete();
    else if (stk.size() < 2) e = 2;
    else begin
      b = stk.pop_back(); a = stk.pop_back();
      case (op)
        OP_ADD: r = a + b;
        OP_SUB: r = a - b;
        OP_MUL: r = a * b;
        OP_AND: r = a & b;
        default: r = a | b;
      endcase
      stk.push_back(r & 255);
      wb = 1;
    end
    cmd_op = op; cmd_data = d; cmd_valid = 1;
    @(posedge CLOCK_50); #1;
    cmd_valid = 0; cmd_data = 8'($urandom); cmd_op = 3'($urandom);
    chk("err_pulse", err_pulse, e != 0);
    chk("err_code", err_code, e);
    if (wb) begin
      chk("wb_ready", cmd_ready, 0);
      @(posedge CLOCK_50); #1;
      chk("wb_pulse", err_pulse, 0);
    end
    chk_state("step");
  endtask
  initial begin
    RESET_N = 0; cmd_valid = 0; cmd_op = 0; cmd_data = 0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_count", count, 0);
    chk("rst_top", top_data, 0);
    chk("rst_tvalid", top_valid, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_code", err_code, 0);
    chk("rst_pulse", err_pulse, 0);
    @(negedge CLOCK_50) RESET_N = 1;
    @(posedge CLOCK_50); #1;
    step(OP_PUSH, 5); step(OP_PUSH, 3); step(OP_SUB, 0);
    chk("sub_lit", top_data, 2);
    chk("sub_count", count, 1);
    step(OP_CLEAR, 0);
    step(OP_PUSH, 200); step(OP_PUSH, 100); step(OP_ADD, 0);
    chk("add_wrap", top_data, 44);
    step(OP_PUSH, 8'h11); step(OP_MUL, 0);
    chk("mul_wrap", top_data, 8'hEC);
    step(OP_CLEAR, 0); step(OP_PUSH, 7); step(OP_ADD, 0);
    chk("udf_top", top_data, 7);
    @(posedge CLOCK_50); #1;
    chk("udf_pulse_drop", err_pulse, 0);
    chk("udf_code_hold", err_code, 2);
    step(OP_POP, 0); step(OP_POP, 0);
    chk("udf_pop_code", err_code, 2);
    for (int i = 1; i <= 5; i++) step(OP_PUSH, 8'(i));
    chk("ovf_code", err_code, 1);
    chk("ovf_top", top_data, 4);
    step(OP_POP, 0); chk("pop1", top_data, 3);
    step(OP_POP, 0); chk("pop2", top_data, 2);
    step(OP_POP, 0); chk("pop3", top_data, 1);
    step(OP_CLEAR, 0); step(OP_PUSH, 9); step(OP_PUSH, 4);
    cmd_op = OP_ADD; cmd_valid = 1;
    @(posedge CLOCK_50); #1;
    cmd_valid = 0;
    chk("abort_in_wb", cmd_ready, 0);
    RESET_N = 0;
    #2;
    stk.delete();
    chk("abort_count", count, 0);
    chk("abort_top", top_data, 0);
    @(negedge CLOCK_50) RESET_N = 1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk_state("abort_after");
    chk("abort_code", err_code, 0);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) == 0) ? OP_CLEAR : 3'($urandom_range(0, 6)), 8'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
